// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, single-outstanding imem request/grant/response port, {pc,instr} buffer to decode.
// Optional FETCH_MISALIGN_CHK_EN: a misaligned redirect target sets sticky misalign_err and halts fetch.
module instr_fetch_unit #(
    parameter int           n         = 32,
    parameter logic [n-1:0] RESET_PC  = {n{1'b0}},
    parameter int           BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         imem_req,
    output logic [n-1:0] imem_addr,
    input  logic         imem_gnt,
    input  logic         imem_rvalid,
    input  logic [n-1:0] imem_rdata,
    output logic [n-1:0] instr_out,
    output logic [n-1:0] pc_out,
    output logic         instr_valid,
    input  logic         instr_ready,
    input  logic         pc_sel,
    input  logic [n-1:0] pc_target,
    output logic         misalign_err
);
    localparam int             PW         = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int             CW         = PW + 1;
    localparam logic [CW-1:0]  DEPTH_C    = CW'(BUF_DEPTH);
    localparam logic [n-1:0]   ALIGN_MASK = ~{{(n-2){1'b0}}, 2'b11};
    localparam logic [n-1:0]   PC_STEP    = {{(n-3){1'b0}}, 3'b100};

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1
`ifdef FETCH_MISALIGN_CHK_EN
        , ST_HALT = 2'd2
`endif
    } state_t;

    state_t        state_r, state_s;
    logic [n-1:0]  fetch_pc_r, fetch_pc_s;
    logic [n-1:0]  imem_addr_r, imem_addr_s;
    logic          imem_req_r, imem_req_s;
    logic [n-1:0]  inflight_pc_r, inflight_pc_s;
    logic          discard_r, discard_s;
    logic [n-1:0]  fifo_instr_r [BUF_DEPTH];
    logic [n-1:0]  fifo_pc_r    [BUF_DEPTH];
    logic [PW-1:0] rd_ptr_r, rd_ptr_s, wr_ptr_r, wr_ptr_s;
    logic [CW-1:0] count_r, count_s;
    logic [n-1:0]  instr_out_r, pc_out_r, head_instr_s, head_pc_s;
    logic          valid_r;
    logic          pop_s, redirect_s, gnt_s, outstanding_s, push_s;
`ifdef FETCH_MISALIGN_CHK_EN
    logic          misalign_r, misalign_s;
`endif

    assign pop_s         = valid_r & instr_ready;
    assign redirect_s    = pop_s & pc_sel;
    assign gnt_s         = imem_req_r & imem_gnt;
    assign outstanding_s = (state_r == ST_WAIT);
    // A response arriving with the redirect belongs to the old stream and is dropped
    assign push_s        = outstanding_s & imem_rvalid & ~discard_r & ~redirect_s;

    // Fetch FSM next state, fetch PC and discard bookkeeping for the single in-flight request
    always_comb begin
        state_s       = state_r;
        fetch_pc_s    = fetch_pc_r;
        inflight_pc_s = inflight_pc_r;
        discard_s     = discard_r;
`ifdef FETCH_MISALIGN_CHK_EN
        misalign_s    = misalign_r;
`endif
        case (state_r)
            ST_REQ: begin
                if (gnt_s) begin
                    state_s       = ST_WAIT;
                    inflight_pc_s = imem_addr_r;
                    // a stale request granted after a redirect must not advance the new PC
                    fetch_pc_s    = discard_r ? fetch_pc_r : (fetch_pc_r + PC_STEP);
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    state_s   = ST_REQ;
                    discard_s = 1'b0;
                end else begin
                    state_s = ST_WAIT;
                end
            end
`ifdef FETCH_MISALIGN_CHK_EN
            ST_HALT: state_s = ST_HALT;
`endif
            default: state_s = ST_REQ;
        endcase
        if (redirect_s) begin
            fetch_pc_s = pc_target & ALIGN_MASK;
            if (imem_req_r || (outstanding_s && !imem_rvalid)) begin
                discard_s = 1'b1;
            end else begin
                discard_s = discard_s;
            end
`ifdef FETCH_MISALIGN_CHK_EN
            if (pc_target[1:0] != 2'b00) begin
                state_s    = ST_HALT;
                misalign_s = 1'b1;
            end else begin
                misalign_s = misalign_s;
            end
`endif
        end else begin
            fetch_pc_s = fetch_pc_s;
        end
    end

    // Request generation: hold req/addr until granted, otherwise request while a slot is free
    always_comb begin
        imem_req_s  = 1'b0;
        imem_addr_s = fetch_pc_s;
        if (imem_req_r && !imem_gnt) begin
            imem_req_s  = 1'b1;
            imem_addr_s = imem_addr_r;
        end else begin
            imem_req_s  = (state_s == ST_REQ) && (count_s < DEPTH_C);
            imem_addr_s = fetch_pc_s;
        end
    end

    // Buffer pointers, occupancy and next registered head (no bypass of the pushed word)
    always_comb begin
        rd_ptr_s     = rd_ptr_r;
        wr_ptr_s     = wr_ptr_r;
        count_s      = count_r;
        head_instr_s = instr_out_r;
        head_pc_s    = pc_out_r;
        if (redirect_s) begin
            rd_ptr_s = {PW{1'b0}};
            wr_ptr_s = {PW{1'b0}};
            count_s  = {CW{1'b0}};
        end else begin
            rd_ptr_s = rd_ptr_r + PW'(pop_s);
            wr_ptr_s = wr_ptr_r + PW'(push_s);
            count_s  = count_r + CW'(push_s) - CW'(pop_s);
            if (count_s == {CW{1'b0}}) begin
                head_instr_s = instr_out_r;
                head_pc_s    = pc_out_r;
            end else if (count_r == CW'(pop_s)) begin
                head_instr_s = imem_rdata;
                head_pc_s    = inflight_pc_r;
            end else begin
                head_instr_s = fifo_instr_r[rd_ptr_s];
                head_pc_s    = fifo_pc_r[rd_ptr_s];
            end
        end
    end

    // Control and output state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_REQ;
            fetch_pc_r    <= RESET_PC;
            imem_addr_r   <= RESET_PC;
            imem_req_r    <= 1'b0;
            inflight_pc_r <= {n{1'b0}};
            discard_r     <= 1'b0;
            rd_ptr_r      <= {PW{1'b0}};
            wr_ptr_r      <= {PW{1'b0}};
            count_r       <= {CW{1'b0}};
            instr_out_r   <= {n{1'b0}};
            pc_out_r      <= {n{1'b0}};
            valid_r       <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_r    <= 1'b0;
`endif
        end else begin
            state_r       <= state_s;
            fetch_pc_r    <= fetch_pc_s;
            imem_addr_r   <= imem_addr_s;
            imem_req_r    <= imem_req_s;
            inflight_pc_r <= inflight_pc_s;
            discard_r     <= discard_s;
            rd_ptr_r      <= rd_ptr_s;
            wr_ptr_r      <= wr_ptr_s;
            count_r       <= count_s;
            instr_out_r   <= head_instr_s;
            pc_out_r      <= head_pc_s;
            valid_r       <= (count_s != {CW{1'b0}});
`ifdef FETCH_MISALIGN_CHK_EN
            misalign_r    <= misalign_s;
`endif
        end
    end

    // Buffer storage
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_instr_r[wr_ptr_r] <= imem_rdata;
            fifo_pc_r[wr_ptr_r]    <= inflight_pc_r;
        end
    end

    assign imem_req    = imem_req_r;
    assign imem_addr   = imem_addr_r;
    assign instr_out   = instr_out_r;
    assign pc_out      = pc_out_r;
    assign instr_valid = valid_r;
`ifdef FETCH_MISALIGN_CHK_EN
    assign misalign_err = misalign_r;
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory responder model plus an in-order pc/instr scoreboard.
module tb_instr_fetch_unit;
    localparam int N = 32;

    logic         clk, rst_n;
    logic         imem_req, imem_gnt, imem_rvalid;
    logic [N-1:0] imem_addr, imem_rdata;
    logic [N-1:0] instr_out, pc_out, pc_target;
    logic         instr_valid, instr_ready, pc_sel, misalign_err;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           pop_cnt  = 0;
    int           gnt_cnt  = 0;
    int           n0;
    logic [N-1:0] exp_pc;
    logic         hold_rsp = 1'b0;
    logic         pend     = 1'b0;
    logic [N-1:0] pend_addr = 32'h0;

    instr_fetch_unit #(.n(N), .RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .pc_sel(pc_sel), .pc_target(pc_target),
        .misalign_err(misalign_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [N-1:0] mem_word(input logic [N-1:0] a);
        mem_word = (a == 32'h0) ? 32'h00500093 : (a ^ 32'hC0DE0013);
    endfunction

    // Instruction memory: grant sampled at the edge, response one cycle later unless held back
    always @(posedge clk) begin
        if (!rst_n) begin
            pend    = 1'b0;
            gnt_cnt = 0;
        end else begin
            if (imem_rvalid === 1'b1) pend = 1'b0;
            if (imem_req === 1'b1 && imem_gnt === 1'b1) begin
                pend      = 1'b1;
                pend_addr = imem_addr;
                gnt_cnt++;
            end
        end
        #1;
        imem_rvalid = pend && !hold_rsp && rst_n;
        imem_rdata  = pend ? mem_word(pend_addr) : 32'h0;
    end

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; a pop happening at the coming edge is checked against the expected pc stream
    task automatic step();
        if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
            chk("pop_pc", pc_out, exp_pc);
            chk("pop_instr", instr_out, mem_word(exp_pc));
            pop_cnt++;
            exp_pc = pc_sel ? (pc_target & 32'hFFFF_FFFC) : (exp_pc + 32'h4);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int k = 0; k < budget && instr_valid !== 1'b1; k++) step();
        chk(tag, {31'h0, instr_valid}, 32'h1);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        instr_ready = 1'b0;
        pc_sel      = 1'b0;
        pc_target   = 32'h0;
        hold_rsp    = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        exp_pc  = 32'h0;
        pop_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state, first fetch latency and address sequence
        do_reset();
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr_out, 32'h0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_misalign", {31'h0, misalign_err}, 32'h0);
        imem_gnt = 1'b1; instr_ready = 1'b1; rst_n = 1'b1;
        step();
        chk("t1_req_c1", {31'h0, imem_req}, 32'h1);
        chk("t1_addr0", imem_addr, 32'h0);
        chk("t1_valid_c1", {31'h0, instr_valid}, 32'h0);
        step();
        chk("t1_valid_c2", {31'h0, instr_valid}, 32'h0);
        step();
        chk("t1_valid_c3", {31'h0, instr_valid}, 32'h1);
        chk("t1_instr", instr_out, 32'h00500093);
        chk("t1_pc", pc_out, 32'h0);
        chk("t1_addr4", imem_addr, 32'h4);
        step(); step();
        chk("t1_addr8", imem_addr, 32'h8);
        repeat (6) step();

        // Back-pressure: buffer fills, requests stop, then drains in order
        instr_ready = 1'b0;
        repeat (10) step();
        chk("t2_req_full", {31'h0, imem_req}, 32'h0);
        chk("t2_valid_full", {31'h0, instr_valid}, 32'h1);
        chk("t2_buffered", 32'(gnt_cnt - pop_cnt), 32'h2);
        n0 = pop_cnt;
        instr_ready = 1'b1;
        repeat (12) step();
        chk("t2_drained", {31'h0, (pop_cnt - n0 >= 5)}, 32'h1);

        // Redirect while the request to 12 is outstanding
        do_reset();
        imem_gnt = 1'b1; instr_ready = 1'b1; rst_n = 1'b1;
        for (int k = 0; k < 20 && !(instr_valid === 1'b1 && pc_out === 32'h8); k++) step();
        chk("t3_head_pc8", pc_out, 32'h8);
        chk("t3_req_addr12", imem_addr, 32'hC);
        instr_ready = 1'b0; hold_rsp = 1'b1;
        step();
        instr_ready = 1'b1; pc_sel = 1'b1; pc_target = 32'h100;
        step();
        pc_sel = 1'b0; hold_rsp = 1'b0;
        chk("t3_flushed", {31'h0, instr_valid}, 32'h0);
        wait_valid("t3_refill", 20);
        chk("t3_pc_target", pc_out, 32'h100);
        step();

        // Redirect in the same cycle as rvalid
        do_reset();
        imem_gnt = 1'b1; rst_n = 1'b1;
        for (int k = 0; k < 10 && !(imem_rvalid === 1'b1 && instr_valid === 1'b1); k++) step();
        chk("t4a_rvalid_cycle", {31'h0, imem_rvalid}, 32'h1);
        instr_ready = 1'b1; pc_sel = 1'b1; pc_target = 32'h200;
        step();
        pc_sel = 1'b0;
        wait_valid("t4a_refill", 20);
        chk("t4a_pc_target", pc_out, 32'h200);
        step();

        // Redirect in the same cycle as gnt
        do_reset();
        imem_gnt = 1'b1; rst_n = 1'b1;
        for (int k = 0; k < 10 && !(imem_req === 1'b1 && instr_valid === 1'b1); k++) step();
        chk("t4b_gnt_cycle", {31'h0, imem_req}, 32'h1);
        instr_ready = 1'b1; pc_sel = 1'b1; pc_target = 32'h300;
        step();
        pc_sel = 1'b0;
        wait_valid("t4b_refill", 20);
        chk("t4b_pc_target", pc_out, 32'h300);
        step();

        // Ungranted request held stable across a redirect, then discarded
        do_reset();
        imem_gnt = 1'b1; rst_n = 1'b1;
        for (int k = 0; k < 10 && !(imem_req === 1'b1 && instr_valid === 1'b1); k++) step();
        imem_gnt = 1'b0; instr_ready = 1'b1; pc_sel = 1'b1; pc_target = 32'h400;
        step();
        pc_sel = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t5_req_hold", {31'h0, imem_req}, 32'h1);
            chk("t5_addr_hold", imem_addr, 32'h4);
        end
        imem_gnt = 1'b1;
        wait_valid("t5_refill", 20);
        chk("t5_pc_target", pc_out, 32'h400);
        step();

        // Asynchronous reset while a response is outstanding
        hold_rsp = 1'b1;
        for (int k = 0; k < 10 && imem_req !== 1'b1; k++) step();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_req", {31'h0, imem_req}, 32'h0);
        chk("t5_rst_addr", imem_addr, 32'h0);
        chk("t5_rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("t5_rst_instr", instr_out, 32'h0);
        chk("t5_rst_pc", pc_out, 32'h0);
        hold_rsp = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        exp_pc = 32'h0; pop_cnt = 0;
        rst_n = 1'b1;
        wait_valid("t5_refetch", 10);
        chk("t5_refetch_pc", pc_out, 32'h0);
        step();

        // Misaligned redirect target
        do_reset();
        imem_gnt = 1'b1; rst_n = 1'b1;
        for (int k = 0; k < 10 && instr_valid !== 1'b1; k++) step();
        instr_ready = 1'b1; pc_sel = 1'b1; pc_target = 32'h102;
        step();
        pc_sel = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        repeat (6) step();
        chk("t6_misalign_set", {31'h0, misalign_err}, 32'h1);
        chk("t6_halt_req", {31'h0, imem_req}, 32'h0);
        chk("t6_halt_valid", {31'h0, instr_valid}, 32'h0);
`else
        chk("t6_misalign_clr", {31'h0, misalign_err}, 32'h0);
        wait_valid("t6_refill", 20);
        chk("t6_pc_aligned", pc_out, 32'h100);
        chk("t6_instr", instr_out, mem_word(32'h100));
        step();
        chk("t6_misalign_still", {31'h0, misalign_err}, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
